// File: rtl/div64by32_seq_pkg.sv
// Shared constants for the sequential 64/32 divider: FSM encodings,
// default widths and the quotient value reported for div0/overflow results.
package div64by32_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam int W_DEF     = 32;
    localparam int CNT_W_DEF = 6;

    // Saturated quotient for the default width; the top uses '1 for any W.
    localparam logic [W_DEF-1:0] QUO_ALL_ONES = '1;

endpackage

// File: rtl/div64by32_seq_div_step.sv
// One combinational radix-2 restoring iteration: shift the next dividend
// bit into the partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quo,
    input  logic [W-1:0] b,
    output logic [W-1:0] rem_n,
    output logic [W-1:0] quo_n
);

    logic [W-1:0] shifted;
    logic         fits;

    // The shifted-out rem MSB makes the (W+1)-bit value >= 2**W > b, so the
    // subtract always fits then; the result is < b and the W-bit difference is exact.
    assign shifted = {rem[W-2:0], quo[W-1]};
    assign fits    = rem[W-1] | (shifted >= b);
    assign rem_n   = fits ? (shifted - b) : shifted;
    assign quo_n   = {quo[W-2:0], fits};

endmodule

// File: rtl/div64by32_seq.sv
// Sequential unsigned 2W/W divider, one quotient bit per clock.
// Divide-by-zero and quotient overflow finish in one cycle with flags set.
module div64by32_seq
    import div64by32_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           div0,
    output logic           ovf
);

    state_t           state_reg;
    logic [W-1:0]     rem_reg;
    logic [W-1:0]     quo_reg;
    logic [W-1:0]     b_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [W-1:0]     q_reg;
    logic [W-1:0]     r_reg;
    logic             div0_reg;
    logic             ovf_reg;

    logic [W-1:0]     rem_next;
    logic [W-1:0]     quo_next;
    logic [W-1:0]     a_hi;
    logic             is_div0;
    logic             is_ovf;
    logic             accept;
    logic             last_step;

    assign a_hi      = a[2*W-1:W];
    assign is_div0   = (b == '0);
    assign is_ovf    = !is_div0 && (a_hi >= b);
    assign accept    = start && (state_reg != S_RUN);
    assign last_step = (cnt_reg == CNT_W'(W - 1));

    div_step #(
        .W(W)
    ) u_step (
        .rem  (rem_reg),
        .quo  (quo_reg),
        .b    (b_reg),
        .rem_n(rem_next),
        .quo_n(quo_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            rem_reg   <= '0;
            quo_reg   <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            div0_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_div0 || is_ovf) begin
                            // Result is known immediately; publish it with the done pulse.
                            state_reg <= S_DONE;
                            q_reg     <= '1;
                            r_reg     <= a[W-1:0];
                            div0_reg  <= is_div0;
                            ovf_reg   <= is_ovf;
                        end else begin
                            state_reg <= S_RUN;
                            rem_reg   <= a_hi;
                            quo_reg   <= a[W-1:0];
                            b_reg     <= b;
                            cnt_reg   <= '0;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (last_step) begin
                        // Outputs keep the previous result until this final step lands.
                        state_reg <= S_DONE;
                        q_reg     <= quo_next;
                        r_reg     <= rem_next;
                        div0_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == S_RUN);
    assign done = (state_reg == S_DONE);
    assign q    = q_reg;
    assign r    = r_reg;
    assign div0 = div0_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_div64by32_seq.sv
// Directed-vector and scoreboard bench for div64by32_seq: table of hand-computed
// results, control-sequencing corner cases, then a randomized identity check.
module tb_div64by32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        div0;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        div0;
        logic        ovf;
        int          lat;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];

    div64by32_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .q    (q),
        .r    (r),
        .div0 (div0),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Called at the negedge of the cycle after the accepting edge.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    // Accept one op, then scramble a/b so the DUT must rely on its own copies.
    task automatic issue(input logic [63:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = $urandom;
    endtask

    task automatic run_op(input logic [63:0] av, input logic [31:0] bv,
                          output int lat, output int bcnt);
        issue(av, bv);
        wait_done(lat, bcnt);
    endtask

    initial begin
        int lat;
        int bcnt;
        int seen;
        logic [63:0] prod;
        logic [63:0] ra;
        logic [31:0] rb;
        logic [31:0] tmp;
        logic        ok;

        vecs[0]  = '{64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33};
        vecs[1]  = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33};
        vecs[2]  = '{64'h0000_0001_0000_0000, 32'd2, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 33};
        vecs[3]  = '{64'h0000_0002_0000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1};
        vecs[4]  = '{64'd123, 32'd0, 32'hFFFF_FFFF, 32'd123, 1'b1, 1'b0, 1};
        vecs[5]  = '{64'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0, 33};
        vecs[6]  = '{64'h0000_0000_DEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 33};
        vecs[7]  = '{64'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 33};
        vecs[8]  = '{64'h0000_0001_0000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 33};
        vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1};
        vecs[10] = '{64'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1};
        vecs[11] = '{64'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0, 33};
        vecs[12] = '{64'd1000000007, 32'd1000, 32'd1000000, 32'd7, 1'b0, 1'b0, 33};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_q", 64'(q), 64'd0);
        chk("reset_r", 64'(r), 64'd0);
        chk("reset_flags", 64'({div0, ovf}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt);
            $display("vec %0d a=%0h b=%0h q=%0h r=%0h div0=%0b ovf=%0b lat=%0d busy=%0d",
                     i, vecs[i].a, vecs[i].b, q, r, div0, ovf, lat, bcnt);
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_busy", i), 64'(bcnt), 64'(vecs[i].lat == 33 ? 32 : 0));
            chk($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
            chk($sformatf("vec%0d_r", i), 64'(r), 64'(vecs[i].r));
            chk($sformatf("vec%0d_flags", i), 64'({div0, ovf}), 64'({vecs[i].div0, vecs[i].ovf}));
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), 64'(done), 64'd0);
        end

        // start asserted in RUN cycle 10 must be ignored
        issue(64'd100, 32'd7);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            start = (lat == 10);
            a     = 64'd9;
            b     = 32'd4;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) lat = -1;
        $display("seq ignore_start q=%0h r=%0h lat=%0d", q, r, lat);
        chk("ignore_lat", 64'(lat), 64'd33);
        chk("ignore_q", 64'(q), 64'd14);
        chk("ignore_r", 64'(r), 64'd2);

        // back-to-back: start accepted in the DONE cycle
        start = 1'b1;
        a     = 64'd9;
        b     = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_hold_q", 64'(q), 64'd14);
        wait_done(lat, bcnt);
        $display("seq back_to_back q=%0h r=%0h lat=%0d", q, r, lat);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_q", 64'(q), 64'd2);
        chk("b2b_r", 64'(r), 64'd1);

        // reset at RUN cycle 5 aborts the op
        issue(64'd100, 32'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", 64'({busy, done, div0, ovf}), 64'd0);
        chk("abort_q", 64'(q), 64'd0);
        chk("abort_r", 64'(r), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_op(64'd100, 32'd7, lat, bcnt);
        $display("seq after_abort q=%0h r=%0h lat=%0d", q, r, lat);
        chk("fresh_lat", 64'(lat), 64'd33);
        chk("fresh_qr", {32'(q), 32'(r)}, {32'd14, 32'd2});

        // randomized scoreboard
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       rb = 32'd1;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = (i % 4 == 0) ? 32'd0 : 32'd2;
                default: rb = $urandom;
            endcase
            tmp = $urandom;
            case ($urandom_range(0, 7))
                0:       ra = {$urandom, $urandom};
                1:       ra = {32'd0, (rb == 0) ? tmp : tmp % rb};
                default: ra = {(rb == 0) ? tmp : tmp % rb, 32'($urandom)};
            endcase
            run_op(ra, rb, lat, bcnt);
            $display("rnd %0d a=%0h b=%0h q=%0h r=%0h div0=%0b ovf=%0b lat=%0d",
                     i, ra, rb, q, r, div0, ovf, lat);
            total++;
            if (rb == 0) begin
                ok = (lat == 1) && div0 && !ovf && (q == 32'hFFFF_FFFF) && (r == ra[31:0]);
            end else if (ra[63:32] >= rb) begin
                ok = (lat == 1) && !div0 && ovf && (q == 32'hFFFF_FFFF) && (r == ra[31:0]);
            end else begin
                prod = 64'(q) * 64'(rb) + 64'(r);
                ok = (lat == 33) && (bcnt == 32) && !div0 && !ovf && (prod == ra) && (r < rb);
            end
            if (!ok) begin
                bad++;
                $display("FAIL rnd%0d got q=%0h r=%0h div0=%0b ovf=%0b lat=%0d exp q*b+r=%0h r<b or flag rule",
                         i, q, r, div0, ovf, lat, ra);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
